// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
// Imported by the detector top and available to anything else on the serial path.
package seq_det_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  // Widest pattern the mask helper can describe; callers truncate to their own MAX_W.
  localparam int unsigned MASK_MAX_W = 32;

  function automatic int unsigned len_w(input int unsigned max_w);
    return $clog2(max_w + 1);
  endfunction

  // Ones in the low `len` bits; len == 0 yields an all-zero mask.
  function automatic logic [MASK_MAX_W-1:0] mask_lsb(input int unsigned len);
    return {MASK_MAX_W{1'b1}} >> (MASK_MAX_W - len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear that coincides with
// an increment leaves the counter at one so that event is not lost.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with a runtime-programmable pattern/length,
// per-cycle overlap mode, input-valid qualifier and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      MAX_W       = 8,
  parameter logic [MAX_W-1:0] DEF_PATTERN = MAX_W'(8'h3A),
  parameter int unsigned      DEF_LEN     = 6,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_seq,
  input  logic                      in_valid,
  input  logic                      ovl_en,
  input  logic                      pat_load,
  input  logic [MAX_W-1:0]          pat_in,
  input  logic [len_w(MAX_W)-1:0]   pat_len,
  input  logic                      cnt_clr,
  output logic                      det_out,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      cfg_err
);

  localparam int unsigned      LEN_W     = len_w(MAX_W);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_W);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

  // The oldest history bit drops out on every shift, so only MAX_W-1 bits are
  // stored; the post-shift window {hist_q, in_seq} is the full MAX_W bits.
  logic [MAX_W-2:0] hist_q, hist_d;
  logic [MAX_W-1:0] pat_q, pat_d, hist_shift, mask;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic             det_q, det_d, cfg_err_q, cfg_err_d;
  logic             accept, len_ok, window_full, hit;

  always_comb begin
    accept      = in_valid & ~pat_load;
    len_ok      = (pat_len != '0) && (pat_len <= MAX_LEN);
    hist_shift  = {hist_q, in_seq};
    mask        = MAX_W'(mask_lsb(32'(len_q)));
    // len_q is never zero, so len_q-1 cannot underflow: equivalent to fill+1 >= len.
    window_full = fill_q >= (len_q - LEN_W'(1));
    hit         = accept && window_full && (((hist_shift ^ pat_q) & mask) == '0);
  end

  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_d     = 1'b0;
    cfg_err_d = 1'b0;
    if (pat_load) begin
      if (len_ok) begin
        pat_d  = pat_in;
        len_d  = pat_len;
        hist_d = '0;
        fill_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (in_valid) begin
      hist_d = hist_shift[MAX_W-2:0];
      det_d  = hit;
      // Non-overlap restarts the window; history keeps shifting but is ignored until refilled.
      if (hit && (ovl_en == OVL_OFF)) begin
        fill_d = '0;
      end else if (fill_q != MAX_LEN) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= DEF_PATTERN;
      len_q     <= DEF_LEN_L;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

  assign det_out = det_q;
  assign cfg_err = cfg_err_q;

endmodule
